imem_fetch_unit: RTL

Parametrised instruction memory with a program-load port and a valid/ready fetch interface. It is the next generation of the processor's fixed 8-bit, 256-entry instruction store. Programs are written at run time through the load port while the block is in BOOT mode. The fetch stage then reads instructions with a 1-cycle registered latency, backpressure, and out-of-range detection.

---
 rtl/imem_fetch_if.sv | 34 +++
 rtl/imem_fetch_unit.sv | 135 +++++++++++++
 2 files changed

// File: rtl/imem_fetch_if.sv
// Fetch-side request/response bus between the fetch stage (master) and the
// instruction memory (slave). rsp_perr exists only when IMEM_PARITY_EN is defined.
interface imem_fetch_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_instr;
    logic              rsp_err;
    logic [ADDR_W-1:0] rsp_addr;
`ifdef IMEM_PARITY_EN
    logic              rsp_perr;
`endif

    modport master (
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_instr, rsp_err, rsp_addr
`ifdef IMEM_PARITY_EN
      , input  rsp_perr
`endif
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_instr, rsp_err, rsp_addr
`ifdef IMEM_PARITY_EN
      , output rsp_perr
`endif
    );
endinterface

// File: rtl/imem_fetch_unit.sv
// Run-time loadable instruction memory with BOOT/RUN/DRAIN modes and a 1-cycle
// valid/ready fetch port. Optional per-word even parity: define IMEM_PARITY_EN.
module imem_fetch_unit #(
    parameter int                DATA_W        = 8,
    parameter int                ADDR_W        = 8,
    parameter int                DEPTH         = 256,
    parameter logic [DATA_W-1:0] NOP_INSTR     = {DATA_W{1'b0}},
    parameter bit                BOOT_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic              load_done,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_err,
    output logic              boot_mode,
    imem_fetch_if.slave       fetch
);
    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {BOOT, RUN, DRAIN} state_t;
    localparam state_t RESET_STATE = BOOT_ON_RESET ? BOOT : RUN;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < DEPTH_C;
    endfunction

    state_t            state;
    logic              rsp_vld_p1;
    logic [DATA_W-1:0] rsp_instr_p1;
    logic              rsp_err_p1;
    logic [ADDR_W-1:0] rsp_addr_p1;
    logic [IDX_W-1:0]  load_idx;
    logic [IDX_W-1:0]  req_idx;
    logic              wr_en;
    logic              accept;

    // Storage is deliberately left out of reset so a loaded program survives it.
    logic [DATA_W-1:0] mem [DEPTH] = '{default: NOP_INSTR};
`ifdef IMEM_PARITY_EN
    logic              par_mem [DEPTH] = '{default: ^NOP_INSTR};
    logic              rsp_perr_p1;
`endif

    assign load_idx = load_addr[IDX_W-1:0];
    assign req_idx  = fetch.req_addr[IDX_W-1:0];
    // rst_n gate drops a write that coincides with an asserted reset.
    assign wr_en    = rst_n & load_we & (state == BOOT) & in_range(load_addr);

    assign fetch.req_ready = (state == RUN) & (~rsp_vld_p1 | fetch.rsp_ready);
    assign accept          = fetch.req_valid & fetch.req_ready;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[load_idx] <= load_data;
`ifdef IMEM_PARITY_EN
            par_mem[load_idx] <= ^load_data;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RESET_STATE;
            boot_mode <= BOOT_ON_RESET;
            load_err  <= 1'b0;
        end else begin
            load_err <= load_we & ~wr_en;
            unique case (state)
                BOOT: begin
                    // A simultaneous load_start keeps us in BOOT.
                    if (load_done && !load_start) begin
                        state     <= RUN;
                        boot_mode <= 1'b0;
                    end
                end
                RUN: begin
                    if (load_start) state <= DRAIN;
                end
                DRAIN: begin
                    if (!rsp_vld_p1 || fetch.rsp_ready) begin
                        state     <= BOOT;
                        boot_mode <= 1'b1;
                    end
                end
                default: begin
                    state     <= RESET_STATE;
                    boot_mode <= BOOT_ON_RESET;
                end
            endcase
        end
    end

    // Stage p1: registered fetch response, held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_vld_p1   <= 1'b0;
            rsp_instr_p1 <= '0;
            rsp_err_p1   <= 1'b0;
            rsp_addr_p1  <= '0;
`ifdef IMEM_PARITY_EN
            rsp_perr_p1  <= 1'b0;
`endif
        end else if (accept) begin
            rsp_vld_p1  <= 1'b1;
            rsp_addr_p1 <= fetch.req_addr;
            if (in_range(fetch.req_addr)) begin
                rsp_instr_p1 <= mem[req_idx];
                rsp_err_p1   <= 1'b0;
`ifdef IMEM_PARITY_EN
                rsp_perr_p1  <= par_mem[req_idx] ^ (^mem[req_idx]);
`endif
            end else begin
                rsp_instr_p1 <= NOP_INSTR;
                rsp_err_p1   <= 1'b1;
`ifdef IMEM_PARITY_EN
                rsp_perr_p1  <= 1'b0;
`endif
            end
        end else if (fetch.rsp_ready) begin
            rsp_vld_p1 <= 1'b0;
        end
    end

    assign fetch.rsp_valid = rsp_vld_p1;
    assign fetch.rsp_instr = rsp_instr_p1;
    assign fetch.rsp_err   = rsp_err_p1;
    assign fetch.rsp_addr  = rsp_addr_p1;
`ifdef IMEM_PARITY_EN
    assign fetch.rsp_perr  = rsp_perr_p1;
`endif
endmodule
